// File: rtl/iob_spi_fl_arbiter.sv
// Round-robin N-port read front-end for the SPI flash controller core, with a
// one-entry last-read hit buffer, a per-transaction timeout and a sticky error flag.
module iob_spi_fl_arbiter #(
    parameter int N_PORTS   = 2,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 4096,
    parameter int HIT_EN    = 1,
    localparam int GW       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        req_valid,
    input  logic [N_PORTS*ADDR_W-1:0] req_addr,
    output logic [N_PORTS-1:0]        req_ready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    output logic                      fl_valid,
    output logic [31:0]               fl_address,
    input  logic                      fl_ready,
    input  logic [DATA_W-1:0]         fl_dataout,
    input  logic                      inval,
    output logic                      err_sticky,
    input  logic                      err_clr,
    output logic [GW-1:0]             grant_idx
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        ptr;
    logic [GW-1:0]        pick_idx;
    logic                 pick_found;
    logic [N_PORTS-1:0]   cand;
    logic [ADDR_W-1:0]    addr_arr [N_PORTS];
    logic [ADDR_W-1:0]    pick_addr;
    logic                 hit;
    logic                 timeout_hit;
    logic [TIMEOUT_W-1:0] cnt;
    logic [DATA_W-1:0]    resp_data;
    logic                 resp_err;
    logic                 buf_vld;
    logic [ADDR_W-1:0]    buf_tag;
    logic [DATA_W-1:0]    buf_data;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end

    // A port whose ready pulse is on the bus this cycle still holds valid; mask it
    // so the completed request is not granted a second time.
    always_comb begin
        logic [GW-1:0] idx;
        cand       = req_valid & ~req_ready;
        pick_found = 1'b0;
        pick_idx   = ptr;
        idx        = ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = GW'((int'(ptr) + k) % N_PORTS);
            if (!pick_found && cand[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    assign pick_addr   = addr_arr[pick_idx];
    assign hit         = (HIT_EN != 0) && buf_vld && (buf_tag == pick_addr) && !inval;
    assign timeout_hit = (state == WAIT) && !fl_ready && (cnt == TIMEOUT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fl_valid  = 1'b0;
        case (state)
            IDLE:    if (pick_found) state_nxt = hit ? RESP : ISSUE;
            ISSUE: begin
                fl_valid  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    if (fl_ready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Response is staged in resp_data/resp_err and presented one cycle after RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            grant_idx  <= '0;
            fl_address <= '0;
            cnt        <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            req_ready  <= '0;
            req_rdata  <= '0;
            req_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            req_ready <= '0;
            req_err   <= 1'b0;
            if (err_clr) err_sticky <= 1'b0;
            case (state)
                IDLE: if (pick_found) begin
                    grant_idx  <= pick_idx;
                    fl_address <= 32'(pick_addr);
                    resp_data  <= buf_data;
                    resp_err   <= 1'b0;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (fl_ready) begin
                        resp_data <= fl_dataout;
                        resp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data  <= '1;
                        resp_err   <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end
                RESP: begin
                    req_ready[grant_idx] <= 1'b1;
                    req_rdata            <= resp_data;
                    req_err              <= resp_err;
                    ptr <= (grant_idx == GW'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    if (HIT_EN != 0) begin : g_buf
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                buf_vld  <= 1'b0;
                buf_tag  <= '0;
                buf_data <= '0;
            end else if (inval) begin
                buf_vld <= 1'b0;
            end else if (state == WAIT && fl_ready) begin
                buf_vld  <= 1'b1;
                buf_tag  <= fl_address[ADDR_W-1:0];
                buf_data <= fl_dataout;
            end
        end
    end else begin : g_nobuf
        assign buf_vld  = 1'b0;
        assign buf_tag  = '0;
        assign buf_data = '0;
    end

endmodule

// File: doc/iob_spi_fl_arbiter.md
Name: iob_spi_fl_arbiter

Overview:
- Parametrised N-port read front-end for the SPI flash controller core. Generalises the earlier fixed two-source mux, which had one cache port and one register port.
- Arbitrates N native read requesters round-robin onto the single controller valid/address/tready/dataout handshake.
- Adds a one-entry last-read hit buffer, a transaction timeout with a sticky error, and buffer invalidation for use after program/erase commands.
- Sits between the CPU/cache/DMA read masters and the controller core inside the flash peripheral.

Parameters:
- N_PORTS, 2, number of requester ports (1..8).
- ADDR_W, 24, flash byte address width.
- DATA_W, 32, read data width.
- TIMEOUT_W, 16, width of the timeout counter.
- TIMEOUT, 4096, cycles in WAIT before an abort (1..2^TIMEOUT_W-1).
- HIT_EN, 1, enables the last-read hit buffer (0 = every request goes to flash).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_PORTS  per-port request; held high until that port's req_ready
- req_addr  in  N_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W]
- req_ready  out  N_PORTS  one-cycle completion pulse to the granted port
- req_rdata  out  DATA_W  shared read data, valid only while a req_ready bit is high
- req_err  out  1  high with req_ready when the response is a timeout abort
- fl_valid  out  1  one-cycle start pulse to the controller
- fl_address  out  32  zero-extended ADDR_W address to the controller
- fl_ready  in  1  controller done pulse (tready)
- fl_dataout  in  DATA_W  controller read data, valid while fl_ready is high
- inval  in  1  clears the hit buffer; pulse after any program/erase
- err_sticky  out  1  set on any timeout; cleared by err_clr
- err_clr  in  1  clears err_sticky
- grant_idx  out  clog2(N_PORTS) (min 1)  index of the current or last granted port

Behaviour:
- Reset values: req_ready=0, req_rdata=0, req_err=0, fl_valid=0, fl_address=0, err_sticky=0, grant_idx=0, state=IDLE, round-robin pointer=0, buffer valid=0, timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward (with wrap) from the pointer.
  - Latch the granted index and address.
  - If HIT_EN, the buffer is valid, the buffer tag equals the address and inval=0: go to RESP with the buffer data. Hit latency is 2 cycles from valid to ready.
  - Otherwise go to ISSUE.
- ISSUE: fl_valid=1 for exactly one cycle with fl_address = latched address; clear the counter; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - On fl_ready: capture fl_dataout, set req_err=0, go to RESP. If HIT_EN, write tag and data and set buffer valid.
  - If the counter reaches TIMEOUT-1 with no fl_ready: req_rdata = all ones, req_err=1, err_sticky set, go to RESP. The buffer is not updated.
  - fl_ready arriving in the timeout cycle takes priority as a normal completion.
- RESP:
  - req_ready[grant]=1 and req_rdata/req_err registered, for one cycle.
  - Pointer = grant+1, wrapping N_PORTS-1 -> 0.
  - Return to IDLE. A new grant occurs at the earliest on the cycle after RESP.
- Fairness: a continuously requesting port waits at most N_PORTS-1 other transactions.
- A requester dropping req_valid after grant does not abort the transaction. The ready pulse is still issued and ignored.
- fl_ready outside WAIT is ignored.
- inval clears buffer valid in any state.
- inval in the same cycle as a WAIT fill: inval wins and the buffer stays invalid.
- inval in the IDLE grant cycle forces a miss.
- err_clr and a timeout in the same cycle: set wins.
- Asynchronous reset mid-transaction returns everything to reset values immediately. fl_valid is low during reset, and no response is issued for the aborted request.
- With HIT_EN=0 the buffer logic is absent and every request goes through ISSUE.
- Only one controller transaction is outstanding at a time.

Test Plan:
- Single read, port 0, addr 0x000100; controller returns 0xDEADBEEF after 20 cycles -> one fl_valid pulse with fl_address=0x00000100; req_ready[0] pulses with rdata=0xDEADBEEF and req_err=0.
- Repeat the same address on port 1 -> no fl_valid; req_ready[1] 2 cycles after valid with rdata=0xDEADBEEF. Pulse inval, repeat again -> fl_valid issued (miss).
- N_PORTS=4, all ports valid continuously for 8 transactions starting at pointer 0 -> grant order 0,1,2,3,0,1,2,3; grant_idx matches each cycle.
- Controller never asserts fl_ready, TIMEOUT=16 -> response 16 cycles after ISSUE with rdata=0xFFFFFFFF, req_err=1, err_sticky=1; err_clr clears it. fl_ready arriving on exactly the 16th WAIT cycle -> normal data and err_sticky stays 0.
- inval asserted in the same cycle as fl_ready with data 0x12345678 -> response carries 0x12345678, but a following same-address request misses.
- Assert rst during WAIT -> all outputs reset asynchronously. After release, a new request on port 1 completes normally from pointer 0.
